datapath_p: RTL and testbench

DATAPATH_P -- requirements
Module: datapath_p

---
 rtl/datapath_p.sv | 164 ++++++++++++++++
 tb/tb_datapath_p.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_p.sv
// datapath_p: fetch/exec datapath, ADD/SUB/LDI/BEQ over an NREG x WIDTH file.
// Define DATAPATH_P_OVF_STICKY_EN to make alu_ovf sticky until rst or start.
module datapath_p #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int AW    = 4,
    localparam int RW   = $clog2(NREG),
    localparam int KA   = (WIDTH > AW) ? WIDTH : AW,
    localparam int K    = (KA > RW) ? KA : RW,
    localparam int IW   = 2 + 2 * RW + K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    output logic             ins_req,
    output logic [AW-1:0]    ins_addr,
    input  logic             ins_ack,
    input  logic [IW-1:0]    ins_data,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [AW-1:0]    pc,
    output logic             alu_eq,
    output logic             alu_ovf,
    output logic             busy,
    output logic             halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    state_e           state_q;
    logic [AW-1:0]    pc_q;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [IW-1:0]    ir_q;
    logic             eq_q;
    logic             ovf_q;
    logic             req_q;
    logic             busy_q;
    logic             halt_q;

    logic [1:0]       op;
    logic [RW-1:0]    f1;
    logic [RW-1:0]    f2;
    logic [K-1:0]     f3;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             eq_d;
    logic             ovf_d;
    logic             ovf_nx;
    logic [AW-1:0]    pc_inc;
    logic [AW-1:0]    tgt;

    assign op     = ir_q[IW-1 -: 2];
    assign f1     = ir_q[IW-3 -: RW];
    assign f2     = ir_q[IW-3-RW -: RW];
    assign f3     = ir_q[K-1:0];
    assign pc_inc = pc_q + AW'(1);
    assign tgt    = f3[AW-1:0];

    always_comb begin
        opa = regs_q[f2];
        opb = regs_q[f3[RW-1:0]];
        if (op == OP_BEQ) begin
            opa = regs_q[f1];
            opb = regs_q[f2];
        end
        res  = op[0] ? (opa - opb) : (opa + opb);
        eq_d = (opa == opb);
        // Signed overflow: result sign disagrees with the operand-sign rule.
        if (op[0]) begin
            ovf_d = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                    (res[WIDTH-1] != opa[WIDTH-1]);
        end else begin
            ovf_d = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                    (res[WIDTH-1] != opa[WIDTH-1]);
        end
`ifdef DATAPATH_P_OVF_STICKY_EN
        ovf_nx = ovf_q | ovf_d;
`else
        ovf_nx = ovf_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            eq_q    <= 1'b0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (start) begin
            // Also aborts an in-flight fetch or exec without any write.
            state_q <= FETCH;
            pc_q    <= start_addr;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            halt_q  <= 1'b0;
`ifdef DATAPATH_P_OVF_STICKY_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ins_ack) begin
                        ir_q    <= ins_data;
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                    end
                end
                EXEC: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    pc_q    <= pc_inc;
                    unique case (op)
                        OP_ADD, OP_SUB: begin
                            regs_q[f1] <= res;
                            eq_q       <= eq_d;
                            ovf_q      <= ovf_nx;
                        end
                        OP_LDI: begin
                            regs_q[f1] <= f3[WIDTH-1:0];
                        end
                        default: begin
                            eq_q <= eq_d;
                            if (eq_d && (tgt == pc_q)) begin
                                state_q <= HALT;
                                req_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                halt_q  <= 1'b1;
                                pc_q    <= pc_q;
                            end else if (eq_d) begin
                                pc_q <= tgt;
                            end
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign ins_req  = req_q;
    assign ins_addr = pc_q;
    assign pc       = pc_q;
    assign alu_eq   = eq_q;
    assign alu_ovf  = ovf_q;
    assign busy     = busy_q;
    assign halted   = halt_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_datapath_p.sv
// tb_datapath_p: directed + random programs vs an instruction-level model.
// Zero-wait memory with optional withheld acks.
module tb_datapath_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  start_addr;
    logic        ins_req;
    logic [3:0]  ins_addr;
    logic        ins_ack;
    logic [13:0] ins_data;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [3:0]  pc;
    logic        alu_eq;
    logic        alu_ovf;
    logic        busy;
    logic        halted;

    logic        hold_ack;
    logic        force_ack;
    logic [13:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_r [4];
    logic [3:0] m_pc;
    logic       m_eq;
    logic       m_ovf;
    logic       m_halt;

    always #5 clk = ~clk;

    assign ins_ack  = (ins_req && !hold_ack) || force_ack;
    assign ins_data = mem[ins_addr];

    datapath_p #(.WIDTH(8), .NREG(4), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .ins_req(ins_req), .ins_addr(ins_addr), .ins_ack(ins_ack),
        .ins_data(ins_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc(pc), .alu_eq(alu_eq), .alu_ovf(alu_ovf), .busy(busy),
        .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] enc(input int op, input int f1,
                                        input int f2, input int f3);
        return {2'(op), 2'(f1), 2'(f2), 8'(f3)};
    endfunction

    function automatic int sgn(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 4'd0;
        m_eq = 1'b0;
        m_ovf = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic model_exec(input logic [13:0] ins);
        int op, f1, f2, f3, a, b, sr;
        bit v;
        op = int'(ins[13:12]);
        f1 = int'(ins[11:10]);
        f2 = int'(ins[9:8]);
        f3 = int'(ins[7:0]);
        if (op <= 1) begin
            a = int'(m_r[f2]);
            b = int'(m_r[f3 % 4]);
            sr = (op == 0) ? sgn(a) + sgn(b) : sgn(a) - sgn(b);
            v = (sr > 127) || (sr < -128);
            m_r[f1] = 8'((sr + 256) % 256);
            m_eq = (a == b);
`ifdef DATAPATH_P_OVF_STICKY_EN
            m_ovf = m_ovf | v;
`else
            m_ovf = v;
`endif
            m_pc = 4'((int'(m_pc) + 1) % 16);
        end else if (op == 2) begin
            m_r[f1] = 8'(f3);
            m_pc = 4'((int'(m_pc) + 1) % 16);
        end else begin
            a = int'(m_r[f1]);
            b = int'(m_r[f2]);
            m_eq = (a == b);
            if (a != b) m_pc = 4'((int'(m_pc) + 1) % 16);
            else if ((f3 % 16) == int'(m_pc)) m_halt = 1'b1;
            else m_pc = 4'(f3 % 16);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_r[i]));
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_eq"}, 32'(alu_eq), 32'(m_eq));
        check({tag, "_ovf"}, 32'(alu_ovf), 32'(m_ovf));
        check({tag, "_halted"}, 32'(halted), 32'(m_halt));
        check({tag, "_busy"}, 32'(busy), 32'(!m_halt));
        check({tag, "_req"}, 32'(ins_req), 32'(!m_halt));
        check_regs(tag);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"}, 32'(ins_req), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_halted"}, 32'(halted), 32'(0));
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        check({tag, "_eq"}, 32'(alu_eq), 32'(m_eq));
        check({tag, "_ovf"}, 32'(alu_ovf), 32'(m_ovf));
        check_regs(tag);
    endtask

    task automatic do_start(input logic [3:0] a);
        start_addr = a;
        start = 1'b1;
        step(1);
        start = 1'b0;
        m_pc = a;
        m_halt = 1'b0;
`ifdef DATAPATH_P_OVF_STICKY_EN
        m_ovf = 1'b0;
`endif
        check_state("start");
    endtask

    task automatic exec_one(input int hold);
        logic [13:0] ins;
        ins = mem[m_pc];
        check("fetch_req", 32'(ins_req), 32'(1));
        check("fetch_addr", 32'(ins_addr), 32'(m_pc));
        if (hold > 0) begin
            hold_ack = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step(1);
                check("hold_req", 32'(ins_req), 32'(1));
                check("hold_addr", 32'(ins_addr), 32'(m_pc));
            end
            hold_ack = 1'b0;
        end
        step(1);
        check("exec_req", 32'(ins_req), 32'(0));
        check("exec_busy", 32'(busy), 32'(1));
        model_exec(ins);
        step(1);
        check_state("retire");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_addr = 4'd0;
        hold_ack = 1'b0;
        force_ack = 1'b0;
        dbg_sel = 2'd0;
        for (int i = 0; i < 16; i++) mem[i] = enc(2, 0, 0, 0);
        model_reset();
        step(2);
        rst = 1'b0;
        check_idle("reset");
        step(1);
        check_idle("idle");

        mem[12] = enc(2, 1, 0, 8'h7F);
        mem[13] = enc(2, 2, 0, 8'h01);
        mem[14] = enc(0, 3, 1, 2);
        mem[15] = enc(2, 2, 0, 8'h01);
        mem[0]  = enc(1, 0, 1, 1);
        mem[1]  = enc(3, 1, 2, 9);
        mem[2]  = enc(2, 2, 0, 8'h33);
        mem[3]  = enc(3, 0, 0, 3);

        do_start(4'd12);
        exec_one(0);
        exec_one(0);
        exec_one(0);
        dbg_sel = 2'd3;
        #1;
        check("add_r3", 32'(dbg_data), 32'h80);
        check("add_ovf", 32'(alu_ovf), 32'(1));
        check("add_eq", 32'(alu_eq), 32'(0));
        exec_one(0);
        check("wrap_pc", 32'(pc), 32'(0));
        exec_one(0);
        dbg_sel = 2'd0;
        #1;
        check("sub_r0", 32'(dbg_data), 32'h00);
        check("sub_eq", 32'(alu_eq), 32'(1));
`ifdef DATAPATH_P_OVF_STICKY_EN
        check("sub_ovf", 32'(alu_ovf), 32'(1));
`else
        check("sub_ovf", 32'(alu_ovf), 32'(0));
`endif
        exec_one(5);
        exec_one(0);
        exec_one(0);
        check("halt_halted", 32'(halted), 32'(1));
        check("halt_busy", 32'(busy), 32'(0));
        check("halt_pc", 32'(pc), 32'(3));
        step(2);
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        check_state("halt_hold");

        do_start(4'd0);
        check("restart_addr", 32'(ins_addr), 32'(0));

        // Abort during EXEC: the LDI must not land.
        mem[0] = enc(2, 3, 0, 8'hAA);
        step(1);
        check("abort_exec_req", 32'(ins_req), 32'(0));
        do_start(4'd7);
        dbg_sel = 2'd3;
        #1;
        check("abort_r3", 32'(dbg_data), 32'h80);

        mem[7] = enc(0, 1, 1, 2);
        step(1);
        check("rst_exec_req", 32'(ins_req), 32'(0));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_reset();
        check_idle("rst_exec");
        step(1);
        check_idle("rst_exec_after");

        do_start(4'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_reset();
        check_idle("rst_fetch");
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        check_idle("idle_ack");

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = 14'($urandom);
            do_start(4'($urandom_range(0, 15)));
            for (int n = 0; n < 20 && !m_halt; n++) begin
                if ($urandom_range(0, 3) == 0) exec_one($urandom_range(1, 3));
                else exec_one(0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
